tpa_param: RTL and testbench
============================

Name: tpa_param

Overview:
- Parametrised second-generation two-port register block with configurable data/address width.
- Port A is the register-interface master (cfg_req/cfg_rdy handshake). Port B is a two-wire serial slave (SCL/SDA).
- SCL and SDA are oversampled in the single clk domain; there is no second clock.
- Adds over the previous generation: explicit address-collision arbitration, stop-bit checking, a serial read-back path, and status flags.

Parameters:
- DATA_W, 16, register word width.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- SYNC_STAGES, 2, synchroniser depth for SCL and SDA (minimum 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- scl  in  1  serial clock from the external master (asynchronous).
- sda_i  in  1  serial data input, the pad value.
- sda_o  out  1  serial data driven by the slave.
- sda_oe  out  1  1 = slave drives the pad.
- cfg_req  in  1  register-interface request.
- cfg_cmd  in  1  1 = write, 0 = read.
- cfg_addr  in  ADDR_W  register address.
- cfg_wdata  in  DATA_W  write data.
- cfg_rdy  out  1  one-cycle completion pulse.
- cfg_rdata  out  DATA_W  read data, valid while cfg_rdy = 1.
- coll_flag  out  1  sticky: a serial write was dropped due to collision.
- ferr_flag  out  1  sticky: serial frame error.
- flag_clr  in  1  clears both sticky flags.

Behaviour:
- Reset values:
  - All DEPTH words = 0.
  - cfg_rdy = 0, cfg_rdata = 0, sda_o = 1, sda_oe = 0, both flags = 0.
  - Both FSMs return to idle; any frame in flight is abandoned.
- Register-interface FSM (C_IDLE, C_ACK, C_WAIT):
  - C_IDLE with cfg_req = 1: at that edge, a write commits cfg_wdata to cfg_addr, or a read captures storage[cfg_addr] into cfg_rdata. Go to C_ACK.
  - C_ACK: cfg_rdy = 1 for exactly one cycle. Go to C_WAIT.
  - C_WAIT: stay until cfg_req = 0, then go to C_IDLE.
  - Net effect: fixed 1-cycle latency, one cfg_rdy pulse per request.
  - cfg_rdata holds its value until the next read.
- Serial sampling:
  - scl and sda_i pass through SYNC_STAGES flops.
  - scl_rise and scl_fall are single-cycle edge detects in the clk domain.
  - Master bits are sampled on scl_rise. The slave updates sda_o/sda_oe on scl_fall.
- Serial frame, all fields LSB first:
  - Line idle is 1. Frame = start(0), cmd(1 = write, 0 = read), ADDR_W address bits.
  - Write continues with DATA_W data bits, then stop(1).
  - Read continues with a turnaround, DATA_W bits driven by the slave, then release.
- Serial FSM states: S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WSTOP, S_TAR, S_RDATA.
  - S_IDLE: sampled 0 → S_CMD; sampled 1 → stay.
  - S_CMD: sampled bit selects the command → S_ADDR.
  - S_ADDR: counts ADDR_W bits, then → S_WDATA (write) or S_TAR (read).
  - S_WDATA: counts DATA_W bits → S_WSTOP.
  - S_WSTOP, stop = 1: commit at the next clk edge → S_IDLE.
  - S_WSTOP, stop = 0: discard the write, set ferr_flag → S_IDLE.
- Serial read:
  - On the edge where the last address bit is sampled, storage[addr] is snapshotted into a shift register (read-before-write semantics).
  - S_TAR: at the next scl_fall, sda_oe = 1 and sda_o = 1 for one SCL period.
  - S_RDATA: on each following scl_fall, sda_o = the next data bit, LSB first.
  - After the last bit's period, at the next scl_fall: sda_oe = 0 → S_IDLE.
- Collision rules:
  - A cfg write and a serial commit in the same cycle to the same address: cfg wins, the serial write is dropped, coll_flag is set.
  - Different addresses: both commit (storage has two write ports).
  - A cfg read in the same cycle as a serial commit to the same address returns the old value.
- Flags:
  - flag_clr has priority over a same-cycle set.
  - coll_flag and ferr_flag are independent.
- Bit counter is ceil(log2(max(ADDR_W, DATA_W) + 1)) bits wide, cleared on every state entry.

Optional Feature:
- Macro: TPA_PARITY_EN.
- Defined, write frames: one even-parity bit over the data follows the data bits, before stop. On mismatch: no commit, ferr_flag set.
- Defined, read frames: the slave appends the even-parity bit after the data, then releases.
- Undefined: no parity bit in either direction; frames are exactly as above.

Decomposition:
- Package tpa_pkg:
  - C_* and S_* state enums.
  - CMD_WRITE = 1'b1, CMD_READ = 1'b0.
  - Function clog2.
- Sub-module tpa_sync_edge: SYNC_STAGES synchroniser plus rise/fall detector. Instanced twice (scl, sda_i); the sda instance ignores its edge outputs.

Test Plan:
- Reset → every output equals its reset value.
- cfg write 0x12 = 0xBEEF, then cfg read 0x12 → cfg_rdy pulses once per request, 1 cycle after req; cfg_rdata = 0xBEEF.
- Serial write addr 0x34, data 0xA5C3, stop = 1 → cfg read of 0x34 returns 0xA5C3. Repeat with stop = 0 → value unchanged, ferr_flag = 1.
- Serial read of 0x12 → sda_oe rises after the address; bits seen are 1, then 0xBEEF LSB first; sda_oe = 0 afterwards.
- Serial write 0x55 = 0x1111 committing in the same cycle as cfg write 0x55 = 0x2222 → storage = 0x2222, coll_flag = 1. flag_clr → 0.
- reset asserted mid serial write (after 4 data bits) → S_IDLE, storage unchanged from reset contents, sda_oe = 0. The next frame is accepted normally.

Source files
------------

// File: rtl/tpa_pkg.sv
// tpa_pkg: shared state encodings, command codes and helpers
// for the tpa_param two-port register block.
package tpa_pkg;

  typedef enum logic [1:0] {
    C_IDLE,
    C_ACK,
    C_WAIT
  } cfg_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_WSTOP,
    S_TAR,
    S_RDATA
  } ser_state_t;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/tpa_sync_edge.sv
// tpa_sync_edge: STAGES-deep synchroniser with rise/fall strobes.
// Resets to 1 so an idle-high line gives no edge out of reset.
module tpa_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              q_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '1;
      q_d <= 1'b1;
    end else begin
      sr  <= {sr[STAGES-2:0], d};
      q_d <= sr[STAGES-1];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/tpa_param.sv
// tpa_param: register file with a cfg_req/cfg_rdy port and a serial slave port.
// Define TPA_PARITY_EN to add an even-parity bit to serial data fields.
module tpa_param
  import tpa_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              sda_oe,
  input  logic              cfg_req,
  input  logic              cfg_cmd,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_rdy,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic              coll_flag,
  output logic              ferr_flag,
  input  logic              flag_clr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int MAXW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = clog2(MAXW + 1);
`ifdef TPA_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WBITS = DATA_W + PAR;

  logic scl_rise, scl_fall, sda_s;
  logic scl_unused_q, sda_unused_rise, sda_unused_fall;

  tpa_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
    .clk  (clk),
    .reset(reset),
    .d    (scl),
    .q    (scl_unused_q),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  tpa_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
    .clk  (clk),
    .reset(reset),
    .d    (sda_i),
    .q    (sda_s),
    .rise (sda_unused_rise),
    .fall (sda_unused_fall)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  cfg_state_t        cst;
  ser_state_t        sst;
  logic [CNT_W-1:0]  cnt;
  logic              cmd;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;
  logic [DATA_W-1:0] rsh;
  logic              s_we;
  logic              cfg_we;
  logic              coll;
  logic              stop_ok;
  logic              ferr_set;
  logic [ADDR_W-1:0] addr_nxt;
`ifdef TPA_PARITY_EN
  logic              s_par;
  logic              rpar;
`endif

  assign cfg_we   = (cst == C_IDLE) & cfg_req & (cfg_cmd == CMD_WRITE);
  assign coll     = s_we & cfg_we & (s_addr == cfg_addr);
  assign addr_nxt = {sda_s, s_addr[ADDR_W-1:1]};
`ifdef TPA_PARITY_EN
  assign stop_ok  = sda_s & (s_par == ^s_data);
`else
  assign stop_ok  = sda_s;
`endif
  assign ferr_set = (sst == S_WSTOP) & scl_rise & ~stop_ok;

  // cfg port is written last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (s_we && !coll) mem[s_addr] <= s_data;
      if (cfg_we) mem[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cst       <= C_IDLE;
      cfg_rdy   <= 1'b0;
      cfg_rdata <= '0;
    end else begin
      cfg_rdy <= 1'b0;
      unique case (cst)
        C_IDLE: if (cfg_req) begin
          if (cfg_cmd == CMD_READ) cfg_rdata <= mem[cfg_addr];
          cfg_rdy <= 1'b1;
          cst     <= C_ACK;
        end
        C_ACK:  cst <= C_WAIT;
        C_WAIT: if (!cfg_req) cst <= C_IDLE;
        default: cst <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coll_flag <= 1'b0;
      ferr_flag <= 1'b0;
    end else if (flag_clr) begin
      coll_flag <= 1'b0;
      ferr_flag <= 1'b0;
    end else begin
      if (coll) coll_flag <= 1'b1;
      if (ferr_set) ferr_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sst    <= S_IDLE;
      cnt    <= '0;
      cmd    <= CMD_READ;
      s_addr <= '0;
      s_data <= '0;
      s_we   <= 1'b0;
      rsh    <= '0;
      sda_o  <= 1'b1;
      sda_oe <= 1'b0;
`ifdef TPA_PARITY_EN
      s_par  <= 1'b0;
      rpar   <= 1'b0;
`endif
    end else begin
      s_we <= 1'b0;
      unique case (sst)
        S_IDLE: if (scl_rise && !sda_s) begin
          sst <= S_CMD;
          cnt <= '0;
        end
        S_CMD: if (scl_rise) begin
          cmd <= sda_s;
          sst <= S_ADDR;
          cnt <= '0;
        end
        S_ADDR: if (scl_rise) begin
          s_addr <= addr_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(ADDR_W - 1)) begin
            // snapshot before any same-edge commit lands
            rsh <= mem[addr_nxt];
`ifdef TPA_PARITY_EN
            rpar <= ^mem[addr_nxt];
`endif
            cnt <= '0;
            sst <= (cmd == CMD_READ) ? S_TAR : S_WDATA;
          end
        end
        S_WDATA: if (scl_rise) begin
          cnt <= cnt + 1'b1;
`ifdef TPA_PARITY_EN
          if (cnt == CNT_W'(DATA_W)) s_par <= sda_s;
          else s_data <= {sda_s, s_data[DATA_W-1:1]};
`else
          s_data <= {sda_s, s_data[DATA_W-1:1]};
`endif
          if (cnt == CNT_W'(WBITS - 1)) begin
            cnt <= '0;
            sst <= S_WSTOP;
          end
        end
        S_WSTOP: if (scl_rise) begin
          s_we <= stop_ok;
          cnt  <= '0;
          sst  <= S_IDLE;
        end
        S_TAR: if (scl_fall) begin
          sda_oe <= 1'b1;
          sda_o  <= 1'b1;
          cnt    <= '0;
          sst    <= S_RDATA;
        end
        S_RDATA: if (scl_fall) begin
          if (cnt == CNT_W'(WBITS)) begin
            sda_oe <= 1'b0;
            sda_o  <= 1'b1;
            cnt    <= '0;
            sst    <= S_IDLE;
          end else begin
            cnt   <= cnt + 1'b1;
            sda_o <= rsh[0];
            rsh   <= rsh >> 1;
`ifdef TPA_PARITY_EN
            if (cnt == CNT_W'(DATA_W)) sda_o <= rpar;
`endif
          end
        end
        default: sst <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpa_param.sv
// tb_tpa_param: randomized + directed bench for tpa_param against a
// memory/flag reference model; serial master and cfg master in tasks.
module tb_tpa_param;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int SYNC = 2;
  localparam int H    = 8;
`ifdef TPA_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, scl_m, sda_m, sda_i, sda_o, sda_oe;
  logic          cfg_req, cfg_cmd, cfg_rdy;
  logic          coll_flag, ferr_flag, flag_clr;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata, cfg_rdata;

  assign sda_i = sda_oe ? sda_o : sda_m;

  tpa_param #(.DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl_m),
    .sda_i    (sda_i),
    .sda_o    (sda_o),
    .sda_oe   (sda_oe),
    .cfg_req  (cfg_req),
    .cfg_cmd  (cfg_cmd),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdy  (cfg_rdy),
    .cfg_rdata(cfg_rdata),
    .coll_flag(coll_flag),
    .ferr_flag(ferr_flag),
    .flag_clr (flag_clr)
  );

  typedef struct {
    bit            rd;
    logic [DW-1:0] val;
    int            cyc;
  } req_t;

  logic [DW-1:0] ref_mem [256];
  bit            exp_coll, exp_ferr;
  req_t          exp_q[$];
  req_t          cmp_e;
  logic [DW-1:0] last_rd;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  bit            oe_idle = 1'b0;
  bit            h_wr, h_clr;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      last_rd = '0;
    end else begin
      if (cfg_rdy) begin
        if (exp_q.size() == 0) begin
          chk("rdy_spurious", 1, 0);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("rdy_latency", cyc, cmp_e.cyc);
          if (cmp_e.rd) begin
            chk("cfg_rdata", cfg_rdata, cmp_e.val);
            last_rd = cmp_e.val;
          end else begin
            chk("rdata_hold", cfg_rdata, last_rd);
          end
        end
      end
      if (oe_idle) chk("sda_oe_idle", sda_oe, 0);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    exp_coll = 0;
    exp_ferr = 0;
    exp_q.delete();
  endtask

  task automatic cfg_issue(input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    req_t e;
    cfg_req   = 1'b1;
    cfg_cmd   = wr;
    cfg_addr  = a;
    cfg_wdata = d;
    e.rd  = !wr;
    e.val = ref_mem[a];
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    if (wr) ref_mem[a] = d;
    @(posedge clk); #1;
    cfg_req = 1'b0;
  endtask

  task automatic cfg_xfer(input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    cfg_issue(wr, a, d);
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic clr_flags();
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    exp_coll = 0;
    exp_ferr = 0;
    @(posedge clk); #1;
    chk("clr_coll", coll_flag, 0);
    chk("clr_ferr", ferr_flag, 0);
  endtask

  // hit: issue the h_* cfg access on the serial commit edge
  task automatic ser_bit(input bit b, input bit hit);
    scl_m = 1'b0;
    sda_m = b;
    repeat (H) @(posedge clk); #1;
    scl_m = 1'b1;
    if (hit) begin
      repeat (SYNC + 1) @(posedge clk); #1;
      flag_clr = h_clr;
      cfg_issue(h_wr, h_addr, h_data);
      flag_clr = 1'b0;
      repeat (H - SYNC - 2) @(posedge clk); #1;
    end else begin
      repeat (H) @(posedge clk); #1;
    end
  endtask

  task automatic ser_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit stop, input bit bad_par, input bit hit);
    bit good;
    ser_bit(1'b0, 1'b0);
    ser_bit(1'b1, 1'b0);
    for (int i = 0; i < AW; i++) ser_bit(a[i], 1'b0);
    for (int i = 0; i < DW; i++) ser_bit(d[i], 1'b0);
`ifdef TPA_PARITY_EN
    ser_bit((^d) ^ bad_par, 1'b0);
`endif
    ser_bit(stop, hit);
    sda_m = 1'b1;
    good = stop && !(PAR == 1 && bad_par);
    if (good) begin
      if (hit && h_wr && h_addr == a) begin
        if (!h_clr) exp_coll = 1;
      end else begin
        ref_mem[a] = d;
      end
    end else begin
      exp_ferr = 1;
    end
    if (hit && h_clr) begin
      exp_coll = 0;
      exp_ferr = 0;
    end
    repeat (2) @(posedge clk); #1;
    chk("coll_flag", coll_flag, exp_coll);
    chk("ferr_flag", ferr_flag, exp_ferr);
  endtask

  task automatic ser_read(input logic [AW-1:0] a, output logic [DW-1:0] got);
    logic [DW-1:0] exp;
    logic [DW+1:0] bits;
    bit            oe_ok;
    exp     = ref_mem[a];
    bits    = '0;
    oe_ok   = 1'b1;
    oe_idle = 1'b0;
    ser_bit(1'b0, 1'b0);
    ser_bit(1'b0, 1'b0);
    for (int i = 0; i < AW; i++) ser_bit(a[i], 1'b0);
    for (int k = 0; k < 1 + DW + PAR; k++) begin
      scl_m = 1'b0;
      sda_m = 1'b1;
      repeat (H) @(posedge clk); #1;
      bits[k] = sda_i;
      if (!sda_oe) oe_ok = 1'b0;
      scl_m = 1'b1;
      repeat (H) @(posedge clk); #1;
    end
    scl_m = 1'b0;
    repeat (H) @(posedge clk); #1;
    scl_m = 1'b1;
    repeat (H) @(posedge clk); #1;
    chk("rd_oe_held", oe_ok, 1);
    chk("rd_turnaround", bits[0], 1);
    got = bits[DW:1];
    chk("rd_data", got, exp);
`ifdef TPA_PARITY_EN
    chk("rd_parity", bits[DW+1], ^exp);
`endif
    chk("rd_release", sda_oe, 0);
    oe_idle = 1'b1;
  endtask

  initial begin
    #600000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int            op;
    logic [AW-1:0] a;
    logic [DW-1:0] d, got;
    reset     = 1'b1;
    scl_m     = 1'b1;
    sda_m     = 1'b1;
    cfg_req   = 1'b0;
    cfg_cmd   = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    flag_clr  = 1'b0;
    h_wr = 0; h_clr = 0; h_addr = '0; h_data = '0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    chk("rst_sda_o", sda_o, 1);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_cfg_rdy", cfg_rdy, 0);
    chk("rst_cfg_rdata", cfg_rdata, 0);
    chk("rst_coll", coll_flag, 0);
    chk("rst_ferr", ferr_flag, 0);
    reset   = 1'b0;
    oe_idle = 1'b1;
    repeat (4) @(posedge clk); #1;

    cfg_xfer(1, 8'h12, 16'hBEEF);
    cfg_xfer(0, 8'h12, '0);
    chk("lit_cfg_beef", cfg_rdata, 16'hBEEF);

    ser_write(8'h34, 16'hA5C3, 1, 0, 0);
    cfg_xfer(0, 8'h34, '0);
    chk("lit_ser_wr", cfg_rdata, 16'hA5C3);
    ser_write(8'h34, 16'h0F0F, 0, 0, 0);
    cfg_xfer(0, 8'h34, '0);
    chk("lit_stop_bad", cfg_rdata, 16'hA5C3);
    chk("lit_ferr", ferr_flag, 1);
    clr_flags();

    ser_read(8'h12, got);
    chk("lit_ser_rd", got, 16'hBEEF);

    h_wr = 1; h_addr = 8'h55; h_data = 16'h2222; h_clr = 0;
    ser_write(8'h55, 16'h1111, 1, 0, 1);
    cfg_xfer(0, 8'h55, '0);
    chk("lit_coll_val", cfg_rdata, 16'h2222);
    chk("lit_coll_flag", coll_flag, 1);
    clr_flags();

    h_wr = 1; h_addr = 8'h57; h_data = 16'h4444;
    ser_write(8'h56, 16'h3333, 1, 0, 1);
    cfg_xfer(0, 8'h56, '0);
    chk("lit_dual_s", cfg_rdata, 16'h3333);
    cfg_xfer(0, 8'h57, '0);
    chk("lit_dual_c", cfg_rdata, 16'h4444);

    h_wr = 0; h_addr = 8'h58; h_data = '0;
    ser_write(8'h58, 16'h5555, 1, 0, 1);
    chk("lit_rd_old", cfg_rdata, 16'h0000);
    cfg_xfer(0, 8'h58, '0);
    chk("lit_rd_new", cfg_rdata, 16'h5555);

    h_wr = 1; h_addr = 8'h55; h_data = 16'h7777; h_clr = 1;
    ser_write(8'h55, 16'h1111, 1, 0, 1);
    h_clr = 0;
    cfg_xfer(0, 8'h55, '0);
    chk("lit_clr_val", cfg_rdata, 16'h7777);
    chk("lit_clr_prio", coll_flag, 0);

    d = 16'hC0DE;
    ser_bit(1'b0, 1'b0);
    ser_bit(1'b1, 1'b0);
    for (int i = 0; i < AW; i++) ser_bit(AW'(8'h66) >> i, 1'b0);
    for (int i = 0; i < 4; i++) ser_bit(d[i], 1'b0);
    reset = 1'b1;
    sda_m = 1'b1;
    repeat (2) @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_oe", sda_oe, 0);
    chk("mid_rst_sda_o", sda_o, 1);
    chk("mid_rst_rdy", cfg_rdy, 0);
    chk("mid_rst_coll", coll_flag, 0);
    chk("mid_rst_ferr", ferr_flag, 0);
    cfg_xfer(0, 8'h12, '0);
    chk("lit_rst_clear", cfg_rdata, 16'h0000);
    ser_write(8'h66, 16'h9876, 1, 0, 0);
    cfg_xfer(0, 8'h66, '0);
    chk("lit_post_rst", cfg_rdata, 16'h9876);

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      a  = AW'($urandom_range(0, 7));
      d  = DW'($urandom);
      if (op <= 2) begin
        cfg_xfer(1, a, d);
      end else if (op <= 4) begin
        cfg_xfer(0, a, '0);
      end else if (op <= 7) begin
        h_wr   = 1'($urandom_range(0, 1));
        h_addr = AW'($urandom_range(0, 7));
        h_data = DW'($urandom);
        h_clr  = 0;
        ser_write(a, d, $urandom_range(0, 5) != 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
      end else if (op == 8) begin
        ser_read(a, got);
      end else begin
        clr_flags();
      end
    end

    repeat (4) @(posedge clk); #1;
    chk("rdy_all_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
